// File: rtl/ddram_arbiter.sv
// Two-client toggle-handshake arbiter feeding the single ddram write/read port.
// One downstream op is in flight at a time; reads return the addressed 16-bit lane.
module ddram_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic [27:0] c0_addr,
  input  logic [15:0] c0_din,
  input  logic        c0_we,
  input  logic        c0_req,
  output logic        c0_ack,
  output logic [15:0] c0_dout,
  input  logic [27:0] c1_addr,
  input  logic [15:0] c1_din,
  input  logic        c1_we,
  input  logic        c1_req,
  output logic        c1_ack,
  output logic [15:0] c1_dout,
  output logic [27:0] wraddr,
  output logic [15:0] din,
  output logic        we_req,
  input  logic        we_ack,
  output logic [27:0] rdaddr,
  output logic        rd_req,
  input  logic        rd_ack,
  input  logic [63:0] dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t      r_state, w_next;
  logic        r_last, r_g, r_req_val;
  logic [1:0]  r_sel;
  logic        r_c0_ack, r_c1_ack, r_we_req, r_rd_req;
  logic [15:0] r_c0_dout, r_c1_dout, r_din;
  logic [27:0] r_wraddr, r_rdaddr;

  logic        w_pend0, w_pend1, w_any, w_grant;
  logic        w_g_we, w_g_req, w_wr_done, w_rd_done;
  logic [27:0] w_g_addr;
  logic [15:0] w_g_din, w_rd_word;

  assign w_pend0   = c0_req ^ r_c0_ack;
  assign w_pend1   = c1_req ^ r_c1_ack;
  assign w_any     = w_pend0 | w_pend1;
  assign w_wr_done = (we_ack == r_we_req);
  assign w_rd_done = (rd_ack == r_rd_req);
  assign w_rd_word = dout[{r_sel, 4'b0000} +: 16];

  // Ties go to c0 in fixed mode, otherwise to whoever was not served last.
  always_comb begin
    w_grant = w_pend1;
    if (w_pend0 && w_pend1)
      w_grant = PRIO_FIXED ? 1'b0 : ~r_last;
  end

  assign w_g_we   = w_grant ? c1_we   : c0_we;
  assign w_g_req  = w_grant ? c1_req  : c0_req;
  assign w_g_addr = w_grant ? c1_addr : c0_addr;
  assign w_g_din  = w_grant ? c1_din  : c0_din;

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = w_g_we ? WR : RD;
      WR:      if (w_wr_done) w_next = IDLE;
      RD:      if (w_rd_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_g       <= 1'b0;
      r_req_val <= 1'b0;
      r_sel     <= 2'd0;
      r_c0_ack  <= 1'b0;
      r_c1_ack  <= 1'b0;
      r_c0_dout <= 16'd0;
      r_c1_dout <= 16'd0;
      r_we_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_wraddr  <= 28'd0;
      r_rdaddr  <= 28'd0;
      r_din     <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_g       <= w_grant;
          r_req_val <= w_g_req;
          r_sel     <= w_g_addr[2:1];
          if (w_g_we) begin
            r_wraddr <= w_g_addr;
            r_din    <= w_g_din;
            r_we_req <= ~r_we_req;
          end else begin
            r_rdaddr <= w_g_addr;
            r_rd_req <= ~r_rd_req;
          end
        end
        WR: if (w_wr_done) begin
          if (r_g) r_c1_ack <= r_req_val;
          else     r_c0_ack <= r_req_val;
          r_last <= r_g;
        end
        RD: if (w_rd_done) begin
          if (r_g) begin
            r_c1_dout <= w_rd_word;
            r_c1_ack  <= r_req_val;
          end else begin
            r_c0_dout <= w_rd_word;
            r_c0_ack  <= r_req_val;
          end
          r_last <= r_g;
        end
        default: ;
      endcase
    end
  end

  assign c0_ack  = r_c0_ack;
  assign c1_ack  = r_c1_ack;
  assign c0_dout = r_c0_dout;
  assign c1_dout = r_c1_dout;
  assign wraddr  = r_wraddr;
  assign din     = r_din;
  assign we_req  = r_we_req;
  assign rdaddr  = r_rdaddr;
  assign rd_req  = r_rd_req;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed-priority; each
// has its own ddram model acking 5 clocks after a request toggle.
module tb_ddram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][27:0] c0_addr, c1_addr, wraddr, rdaddr;
  logic [1:0][15:0] c0_din, c1_din, c0_dout, c1_dout, din;
  logic [1:0]       c0_we, c1_we, c0_req, c1_req, c0_ack, c1_ack;
  logic [1:0]       we_req, we_ack, rd_req, rd_ack, busy, hold_w;
  logic [63:0]      dq = 64'h4444_3333_2222_1111;
  int wcnt [2];
  int rcnt [2];
  int n_cmp = 0;
  int n_err = 0;

  ddram_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
    .DDRAM_CLK(clk), .reset(reset),
    .c0_addr(c0_addr[0]), .c0_din(c0_din[0]), .c0_we(c0_we[0]), .c0_req(c0_req[0]),
    .c0_ack(c0_ack[0]), .c0_dout(c0_dout[0]),
    .c1_addr(c1_addr[0]), .c1_din(c1_din[0]), .c1_we(c1_we[0]), .c1_req(c1_req[0]),
    .c1_ack(c1_ack[0]), .c1_dout(c1_dout[0]),
    .wraddr(wraddr[0]), .din(din[0]), .we_req(we_req[0]), .we_ack(we_ack[0]),
    .rdaddr(rdaddr[0]), .rd_req(rd_req[0]), .rd_ack(rd_ack[0]), .dout(dq), .busy(busy[0]));

  ddram_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
    .DDRAM_CLK(clk), .reset(reset),
    .c0_addr(c0_addr[1]), .c0_din(c0_din[1]), .c0_we(c0_we[1]), .c0_req(c0_req[1]),
    .c0_ack(c0_ack[1]), .c0_dout(c0_dout[1]),
    .c1_addr(c1_addr[1]), .c1_din(c1_din[1]), .c1_we(c1_we[1]), .c1_req(c1_req[1]),
    .c1_ack(c1_ack[1]), .c1_dout(c1_dout[1]),
    .wraddr(wraddr[1]), .din(din[1]), .we_req(we_req[1]), .we_ack(we_ack[1]),
    .rdaddr(rdaddr[1]), .rd_req(rd_req[1]), .rd_ack(rd_ack[1]), .dout(dq), .busy(busy[1]));

  // ddram model: ack follows the request toggle on the 5th clock after it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      we_ack <= '0; rd_ack <= '0;
      for (int k = 0; k < 2; k++) begin wcnt[k] <= 0; rcnt[k] <= 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we_req[k] != we_ack[k] && !hold_w[k]) begin
          if (wcnt[k] == 4) begin we_ack[k] <= we_req[k]; wcnt[k] <= 0; end
          else wcnt[k] <= wcnt[k] + 1;
        end
        if (rd_req[k] != rd_ack[k]) begin
          if (rcnt[k] == 4) begin rd_ack[k] <= rd_req[k]; rcnt[k] <= 0; end
          else rcnt[k] <= rcnt[k] + 1;
        end
      end
    end
  end

  function automatic logic ackv(input int k, input int cl);
    return (cl != 0) ? c1_ack[k] : c0_ack[k];
  endfunction

  function automatic logic reqv(input int k, input int cl);
    return (cl != 0) ? c1_req[k] : c0_req[k];
  endfunction

  task automatic req(input int k, input int cl, input logic we, input logic [27:0] a,
                     input logic [15:0] d);
    if (cl == 0) begin
      c0_addr[k] = a; c0_din[k] = d; c0_we[k] = we; c0_req[k] = ~c0_req[k];
    end else begin
      c1_addr[k] = a; c1_din[k] = d; c1_we[k] = we; c1_req[k] = ~c1_req[k];
    end
  endtask

  task automatic wait_ack(input int k, input int cl);
    int cyc = 0;
    while (ackv(k, cl) !== reqv(k, cl) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c0_addr = '0; c1_addr = '0; c0_din = '0; c1_din = '0;
    c0_we = '0; c1_we = '0; c0_req = '0; c1_req = '0; hold_w = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({wraddr[k], din[k], we_req[k], rdaddr[k], rd_req[k], c0_ack[k], c1_ack[k],
           c0_dout[k], c1_dout[k], busy[k]} !== '0) begin
        n_err++; $display("FAIL reset_outputs inst%0d: got nonzero outputs, want all 0", k);
      end
    end
  endtask

  task automatic test_write();
    int n = 1, wa = -1, aa = -1;
    req(0, 0, 1'b1, 28'h0000102, 16'hBEEF);
    @(negedge clk);
    n_cmp++; if (wraddr[0] !== 28'h102) begin n_err++; $display("FAIL wr_addr: got %h want 0000102", wraddr[0]); end
    n_cmp++; if (din[0] !== 16'hBEEF) begin n_err++; $display("FAIL wr_din: got %h want beef", din[0]); end
    n_cmp++; if (we_req[0] !== 1'b1) begin n_err++; $display("FAIL wr_we_req: got %b want 1", we_req[0]); end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (we_ack[0] && wa < 0) wa = i;
      if (c0_ack[0] && aa < 0) aa = i;
      if (busy[0]) n++;
    end
    n_cmp++; if (wa !== 5) begin n_err++; $display("FAIL wr_we_ack_cycle: got %0d want 5", wa); end
    n_cmp++; if (aa !== 6) begin n_err++; $display("FAIL wr_c0_ack_cycle: got %0d want 6", aa); end
    n_cmp++; if (n !== 6) begin n_err++; $display("FAIL wr_busy_cycles: got %0d want 6", n); end
  endtask

  task automatic test_read();
    req(0, 1, 1'b0, 28'h0000106, 16'h0);
    @(negedge clk);
    n_cmp++; if (rdaddr[0] !== 28'h106) begin n_err++; $display("FAIL rd_addr: got %h want 0000106", rdaddr[0]); end
    n_cmp++; if (rd_req[0] !== 1'b1) begin n_err++; $display("FAIL rd_req_toggle: got %b want 1", rd_req[0]); end
    wait_ack(0, 1);
    n_cmp++; if (c1_ack[0] !== 1'b1) begin n_err++; $display("FAIL rd_c1_ack: got %b want 1", c1_ack[0]); end
    n_cmp++; if (c1_dout[0] !== 16'h4444) begin n_err++; $display("FAIL rd_lane3: got %h want 4444", c1_dout[0]); end
    n_cmp++; if (c0_dout[0] !== 16'h0) begin n_err++; $display("FAIL rd_c0_dout_kept: got %h want 0000", c0_dout[0]); end
    req(0, 1, 1'b0, 28'h0000100, 16'h0);
    @(negedge clk);
    n_cmp++; if (rd_req[0] !== 1'b0) begin n_err++; $display("FAIL rd_req_toggle2: got %b want 0", rd_req[0]); end
    wait_ack(0, 1);
    n_cmp++; if (c1_dout[0] !== 16'h1111) begin n_err++; $display("FAIL rd_lane0: got %h want 1111", c1_dout[0]); end
    n_cmp++; if (wraddr[0] !== 28'h102) begin n_err++; $display("FAIL wraddr_hold: got %h want 0000102", wraddr[0]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      req(0, 0, 1'b1, 28'h10, 16'h1); req(0, 1, 1'b1, 28'h20, 16'h2);
      @(negedge clk);
      n_cmp++; if (wraddr[0] !== 28'h10) begin n_err++; $display("FAIL rr_first%0d: got %h want 0000010", r, wraddr[0]); end
      wait_ack(0, 0);
      n_cmp++; if (c1_ack[0] === c1_req[0]) begin n_err++; $display("FAIL rr_c1_early%0d: got ack %b want pending", r, c1_ack[0]); end
      if (r == 1) req(0, 0, 1'b1, 28'h10, 16'h3);
      @(negedge clk);
      n_cmp++; if (wraddr[0] !== 28'h20) begin n_err++; $display("FAIL rr_second%0d: got %h want 0000020", r, wraddr[0]); end
      wait_ack(0, 1);
      n_cmp++; if (c1_ack[0] !== c1_req[0]) begin n_err++; $display("FAIL rr_c1_done%0d: got %b want %b", r, c1_ack[0], c1_req[0]); end
      if (r == 1) begin
        @(negedge clk);
        n_cmp++; if (wraddr[0] !== 28'h10) begin n_err++; $display("FAIL rr_third: got %h want 0000010", wraddr[0]); end
        wait_ack(0, 0);
      end
    end
  endtask

  task automatic test_fixed_prio();
    int bad = 0;
    do_reset();
    req(1, 0, 1'b1, 28'h40, 16'h0); req(1, 1, 1'b1, 28'h80, 16'h8);
    for (int i = 0; i < 10; i++) begin
      wait_ack(1, 0);
      if (c0_ack[1] !== c0_req[1] || c1_ack[1] !== 1'b0) bad++;
      if (i < 9) req(1, 0, 1'b1, 28'h40 + 28'(i), 16'(i));
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fx_c0_only: got %0d bad ops want 0", bad); end
    wait_ack(1, 1);
    n_cmp++; if (c1_ack[1] !== 1'b1) begin n_err++; $display("FAIL fx_c1_served: got %b want 1", c1_ack[1]); end
    n_cmp++; if (wraddr[1] !== 28'h80) begin n_err++; $display("FAIL fx_c1_addr: got %h want 0000080", wraddr[1]); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req(0, 1, 1'b0, 28'h106, 16'h0);
    wait_ack(0, 1);
    hold_w[0] = 1'b1;
    req(0, 0, 1'b1, 28'h300, 16'hAAAA);
    repeat (3) @(negedge clk);
    n_cmp++; if (busy[0] !== 1'b1 || we_req[0] !== 1'b1) begin n_err++; $display("FAIL mid_wr_busy: got busy %b we_req %b want 1 1", busy[0], we_req[0]); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({wraddr[0], din[0], we_req[0], rdaddr[0], rd_req[0], c0_ack[0], c1_ack[0],
         c0_dout[0], c1_dout[0], busy[0]} !== '0) begin
      n_err++; $display("FAIL async_reset: got wraddr %h din %h c1_dout %h busy %b want all 0",
                        wraddr[0], din[0], c1_dout[0], busy[0]);
    end
    c0_req = '0; c1_req = '0; hold_w = '0;
    @(negedge clk);
    reset = 1'b0;
    req(0, 1, 1'b0, 28'h100, 16'h0);
    wait_ack(0, 1);
    n_cmp++; if (c1_ack[0] !== 1'b1 || c1_dout[0] !== 16'h1111) begin n_err++; $display("FAIL post_reset_rd: got ack %b dout %h want 1 1111", c1_ack[0], c1_dout[0]); end
  endtask

  task automatic test_back_to_back();
    logic we0, rd0;
    int early = 0, cyc = 0;
    we0 = we_req[0]; rd0 = rd_req[0];
    req(0, 0, 1'b0, 28'h200, 16'h0);
    @(negedge clk);
    n_cmp++; if (rd_req[0] !== ~rd0) begin n_err++; $display("FAIL b2b_rd_first: got %b want %b", rd_req[0], ~rd0); end
    while (c0_ack[0] !== c0_req[0] && cyc < 100) begin
      if (we_req[0] !== we0) early++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (c0_dout[0] !== 16'h1111) begin n_err++; $display("FAIL b2b_rd_data: got %h want 1111", c0_dout[0]); end
    req(0, 0, 1'b1, 28'h200, 16'h5555);
    n_cmp++; if (early !== 0 || we_req[0] !== we0) begin n_err++; $display("FAIL b2b_wr_early: got %0d early toggles want 0", early); end
    @(negedge clk);
    n_cmp++; if (we_req[0] !== ~we0 || wraddr[0] !== 28'h200) begin n_err++; $display("FAIL b2b_wr_issue: got we_req %b addr %h want %b 0000200", we_req[0], wraddr[0], ~we0); end
    wait_ack(0, 0);
    n_cmp++; if (c0_ack[0] !== c0_req[0] || c0_dout[0] !== 16'h1111) begin n_err++; $display("FAIL b2b_wr_done: got ack %b dout %h want %b 1111", c0_ack[0], c0_dout[0], c0_req[0]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
